four: RTL and testbench

- Registered priority encoder: scans a WIDTH-bit request vector W, reports the index of the highest-numbered asserted bit on Y, and flags "any bit set" on z.
- Default configuration is the classic 4-to-2 priority encoder (W[3] highest priority).
- Used as a leaf arbiter/index generator; outputs are registered so downstream logic sees a clean one-cycle-latency result.

---
 rtl/four_pkg.sv | 21 ++
 rtl/four_prio_comb.sv | 34 +++
 rtl/four.sv | 50 +++++
 tb/tb_four.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/four_pkg.sv
// ---------------------------------------------------------------------------
// four_pkg
//   Shared constants and helpers for the registered priority encoder.
//   DEFAULT_WIDTH : default number of request inputs (classic 4-to-2 encoder)
//   MIN_WIDTH     : smallest supported request vector width
//   MAX_WIDTH     : largest supported request vector width
//   idx_width()   : width of the encoded index needed for a given request width
// ---------------------------------------------------------------------------
package four_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

  // Index width for a WIDTH-bit request vector; never below one bit so the
  // index port always exists.
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/four_prio_comb.sv
// ---------------------------------------------------------------------------
// four_prio_comb
//   Purely combinational priority encoder: reports the index of the
//   highest-numbered set bit of the request vector and whether any bit is set.
//   Ports:
//     w      in  WIDTH  request vector, higher index = higher priority
//     y_next out IDX_W  index of the highest set bit (0 when w is zero)
//     z_next out 1      1 when at least one request bit is set
// ---------------------------------------------------------------------------
module four_prio_comb
  import four_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] w,
  output logic [IDX_W-1:0] y_next,
  output logic             z_next
);

  // Scanning upward and letting every later hit overwrite the earlier one
  // leaves the highest set bit as the winner. With w zero nothing overwrites
  // the zero default, so the index is driven to 0 as consumers expect.
  always_comb begin
    y_next = '0;
    z_next = |w;
    for (int i = 0; i < WIDTH; i++) begin
      if (w[i]) begin
        y_next = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/four.sv
// ---------------------------------------------------------------------------
// four
//   Registered priority encoder. One clock of latency from W to Y/z; there is
//   no combinational path from the request vector to the outputs.
//   Ports:
//     clk  in  1      system clock, rising edge
//     rst  in  1      synchronous active-high reset, wins over en
//     en   in  1      capture enable; outputs hold while low
//     W    in  WIDTH  request vector, higher index = higher priority
//     Y    out IDX_W  registered index of the highest set bit of W
//     z    out 1      registered "any request set" flag
// ---------------------------------------------------------------------------
module four
  import four_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] W,
  output logic [IDX_W-1:0] Y,
  output logic             z
);

  logic [IDX_W-1:0] y_next;
  logic             z_next;

  four_prio_comb #(
    .WIDTH (WIDTH)
  ) u_prio (
    .w      (W),
    .y_next (y_next),
    .z_next (z_next)
  );

  // Single output stage. Reset is checked first so a pending result is
  // discarded even when en is high in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y <= '0;
      z <= 1'b0;
    end else if (en) begin
      Y <= y_next;
      z <= z_next;
    end
  end

endmodule

// File: tb/tb_four.sv
// ---------------------------------------------------------------------------
// tb_four
//   Bench for the registered priority encoder. Drives a WIDTH=4 and a WIDTH=5
//   instance side by side; expected outputs are queued when stimulus is
//   applied and popped after the capturing clock edge.
// ---------------------------------------------------------------------------
module tb_four;

  typedef struct packed {
    logic [1:0] y4;
    logic       z4;
    logic [2:0] y5;
    logic       z5;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] w4;
  logic [4:0] w5;
  logic [1:0] y4;
  logic       z4;
  logic [2:0] y5;
  logic       z5;

  exp_t sb[$];
  exp_t model;

  int assertions;
  int failures;

  four dut4 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .W   (w4),
    .Y   (y4),
    .z   (z4)
  );

  four #(
    .WIDTH (5)
  ) dut5 (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .W   (w5),
    .Y   (y5),
    .z   (z5)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference encoder: scans downward from the top and stops at the first
  // set bit.
  function automatic int refIndex(input logic [31:0] v, input int width);
    for (int i = width - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Applies inputs at the falling edge, advances the model of the output
  // register and queues the value the DUTs must show after the next edge.
  task automatic applyStimulus(input logic r, input logic e,
                               input logic [3:0] v4, input logic [4:0] v5);
    @(negedge clk);
    rst = r;
    en  = e;
    w4  = v4;
    w5  = v5;
    if (r) begin
      model = '0;
    end else if (e) begin
      model.y4 = 2'(refIndex({28'd0, v4}, 4));
      model.z4 = (v4 != 4'd0);
      model.y5 = 3'(refIndex({27'd0, v5}, 5));
      model.z5 = (v5 != 5'd0);
    end
    sb.push_back(model);
  endtask

  // Waits for the capturing edge, samples 1 unit later, pops and compares.
  task automatic stepAndCheck(input string tag);
    exp_t exp;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      checkOutput({tag, "_y4"}, {30'd0, y4}, {30'd0, exp.y4});
      checkOutput({tag, "_z4"}, {31'd0, z4}, {31'd0, exp.z4});
      checkOutput({tag, "_y5"}, {29'd0, y5}, {29'd0, exp.y5});
      checkOutput({tag, "_z5"}, {31'd0, z5}, {31'd0, exp.z5});
    end
  endtask

  task automatic cycle(input string tag, input logic r, input logic e,
                       input logic [3:0] v4, input logic [4:0] v5);
    applyStimulus(r, e, v4, v5);
    stepAndCheck(tag);
  endtask

  initial begin
    logic [3:0] sweep;
    assertions = 0;
    failures   = 0;
    model      = '0;
    rst = 1'b1;
    en  = 1'b1;
    w4  = 4'b1111;
    w5  = 5'b11111;

    // Reset held two cycles with all requests set, then released.
    cycle("rst0", 1'b1, 1'b1, 4'b1111, 5'b11111);
    cycle("rst1", 1'b1, 1'b1, 4'b1111, 5'b11111);
    checkOutput("rst_y_zero", {30'd0, y4}, 32'd0);
    checkOutput("rst_z_zero", {31'd0, z4}, 32'd0);
    cycle("rst_release", 1'b0, 1'b1, 4'b1111, 5'b11111);
    checkOutput("release_y", {30'd0, y4}, 32'd3);

    // Exhaustive sweep of the 4-bit vector ending on zero.
    for (int i = 1; i <= 16; i++) begin
      sweep = 4'(i);
      cycle($sformatf("sweep_%0d", i & 15), 1'b0, 1'b1, sweep, {1'b0, sweep});
    end
    checkOutput("zero_z", {31'd0, z4}, 32'd0);

    // Lower set bits must be ignored under a higher one.
    cycle("prio_0101", 1'b0, 1'b1, 4'b0101, 5'b00101);
    checkOutput("prio_0101_y", {30'd0, y4}, 32'd2);
    cycle("prio_1011", 1'b0, 1'b1, 4'b1011, 5'b01011);
    cycle("prio_0011", 1'b0, 1'b1, 4'b0011, 5'b00011);

    // Enable low holds the previous result.
    cycle("en_load", 1'b0, 1'b1, 4'b1000, 5'b01000);
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("en_hold_%0d", i), 1'b0, 1'b0, 4'b0001, 5'b00001);
    end
    checkOutput("hold_y", {30'd0, y4}, 32'd3);
    cycle("en_resume", 1'b0, 1'b1, 4'b0001, 5'b00001);
    checkOutput("resume_y", {30'd0, y4}, 32'd0);

    // Reset wins over enable, then normal capture resumes.
    cycle("rst_over_en", 1'b1, 1'b1, 4'b0100, 5'b00100);
    cycle("after_rst", 1'b0, 1'b1, 4'b0100, 5'b00100);

    // WIDTH=5 boundary patterns.
    cycle("w5_top", 1'b0, 1'b1, 4'b0000, 5'b10000);
    checkOutput("w5_top_y", {29'd0, y5}, 32'd4);
    cycle("w5_mid", 1'b0, 1'b1, 4'b0000, 5'b00110);
    cycle("w5_zero", 1'b0, 1'b1, 4'b0000, 5'b00000);

    // Randomised traffic with occasional enable drops and resets.
    for (int i = 0; i < 40; i++) begin
      cycle($sformatf("rand_%0d", i), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), 4'($urandom), 5'($urandom));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule
